// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Fetch-stage bundle: imem request/response and the
//               instruction handshake toward control.
// Revision    : 1.0
// ============================================================================
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ack;
  logic [XLEN-1:0] instr;
  logic [10:0]     ctrl_instr;
  logic [XLEN-1:0] pc_out;
  logic            instr_valid;
  logic            instr_ready;
  logic            branch;
  logic            zero;
  logic [XLEN-1:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr, ctrl_instr, pc_out, instr_valid,
    input  imem_rdata, imem_ack, instr_ready, branch, zero, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, ctrl_instr, pc_out, instr_valid,
    output imem_rdata, imem_ack, instr_ready, branch, zero, branch_target
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : RV32 fetch stage: PC, one-outstanding imem request, captured
//               word with valid/ready handoff, BEQ redirect on retire.
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus,
  output logic          misalign_err,
  output logic          timeout_err
);

  localparam logic [3:0]      c_timeout = TIMEOUT[3:0];
  localparam logic [XLEN-1:0] c_pc_step = {{(XLEN-3){1'b0}}, 3'd4};

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_req;
  logic            w_valid;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic [3:0]      r_wait_cnt;
  logic            r_misalign;
  logic            r_timeout;

  logic            w_capture;
  logic            w_retire;
  logic            w_taken;
  logic            w_misalign;
  logic [XLEN-1:0] w_pc_nxt;
  logic [3:0]      w_wait_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_req = 1'b1;
        if (bus.imem_ack) begin
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        w_valid = 1'b1;
        if (bus.instr_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign w_capture  = (r_state == S_REQ) && bus.imem_ack;
  assign w_retire   = (r_state == S_VALID) && bus.instr_ready;
  assign w_taken    = w_retire && bus.branch && bus.zero;
  assign w_misalign = w_taken && (bus.branch_target[1:0] != 2'b00);
  // Taken targets are forced word-aligned; misalignment is only flagged.
  assign w_pc_nxt   = w_taken ? {bus.branch_target[XLEN-1:2], 2'b00} : r_pc + c_pc_step;
  assign w_wait_inc = (r_wait_cnt == 4'hF) ? 4'hF : r_wait_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_pc_out   <= '0;
      r_wait_cnt <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr  <= bus.imem_rdata;
        r_pc_out <= r_pc;
      end
      if ((r_state == S_REQ) && !bus.imem_ack) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == c_timeout) begin
          r_timeout <= 1'b1;
        end
      end
      if (w_retire) begin
        r_pc       <= w_pc_nxt;
        r_wait_cnt <= '0;
        if (w_misalign) begin
          r_misalign <= 1'b1;
        end
      end
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.ctrl_instr  = {r_instr[30], r_instr[14:12], r_instr[6:0]};
  assign bus.pc_out      = r_pc_out;
  assign bus.instr_valid = w_valid;
  assign misalign_err    = r_misalign;
  assign timeout_err     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0
// ============================================================================
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  logic misalign_err;
  logic timeout_err;
  int   n_vec;
  int   n_miscmp;

  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .TIMEOUT  (15)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for a request, check its address, ack after lat cycles, check capture.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [31:0] word, input int lat);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    check({tag, "_addr"}, bus.imem_addr, exp_addr);
    repeat (lat) @(negedge clk);
    bus.imem_rdata = word;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    check({tag, "_vld"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_instr"}, bus.instr, word);
    check({tag, "_pcout"}, bus.pc_out, exp_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec             = 0;
    n_miscmp          = 0;
    rst_n             = 1'b0;
    bus.imem_rdata    = '0;
    bus.imem_ack      = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch        = 1'b0;
    bus.zero          = 1'b0;
    bus.branch_target = '0;

    repeat (3) @(negedge clk);
    check("rst_vld",   32'(bus.instr_valid), 32'd0);
    check("rst_req",   32'(bus.imem_req),    32'd0);
    check("rst_instr", bus.instr,            32'd0);
    check("rst_pcout", bus.pc_out,           32'd0);
    check("rst_ctrl",  32'(bus.ctrl_instr),  32'd0);
    check("rst_mis",   32'(misalign_err),    32'd0);
    check("rst_tmo",   32'(timeout_err),     32'd0);
    rst_n = 1'b1;
    check("boot_req", 32'(bus.imem_req), 32'd0);

    // LW at 0, ack one cycle after request
    bus.instr_ready = 1'b1;
    serve("t1", 32'h0, 32'h0000_2083, 1);
    check("t1_ctrl", 32'(bus.ctrl_instr), 32'h103);
    @(negedge clk);

    // downstream stall, stray ack while VALID
    bus.instr_ready = 1'b0;
    serve("t2", 32'h4, 32'h0040_0093, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_ack   = 1'b1;
      end
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("t2_vld",   32'(bus.instr_valid), 32'd1);
      check("t2_req",   32'(bus.imem_req),    32'd0);
      check("t2_instr", bus.instr,            32'h0040_0093);
      check("t2_pcout", bus.pc_out,           32'h4);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);

    serve("t3a", 32'h8, 32'h0000_0013, 0);
    @(negedge clk);
    serve("t3b", 32'hC, 32'h0000_0013, 0);
    @(negedge clk);

    // BEQ taken 0x10 -> 0x40
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h40;
    serve("beq_t", 32'h10, 32'h0200_0063, 0);
    check("beq_ctrl", 32'(bus.ctrl_instr), 32'h063);
    @(negedge clk);
    bus.branch_target = 32'h10;
    serve("t3c", 32'h40, 32'h0000_0013, 0);
    check("t3c_mis", 32'(misalign_err), 32'd0);
    @(negedge clk);

    // BEQ not taken at 0x10 -> 0x14
    bus.zero = 1'b0; bus.branch_target = 32'h40;
    serve("beq_nt", 32'h10, 32'h0200_0063, 0);
    @(negedge clk);

    // misaligned taken target 0x42 -> fetch 0x40, sticky error
    bus.zero = 1'b1; bus.branch_target = 32'h42;
    serve("t4a", 32'h14, 32'h0200_0163, 0);
    check("t4a_mis0", 32'(misalign_err), 32'd0);
    @(negedge clk);
    check("t4a_mis1", 32'(misalign_err), 32'd1);
    bus.branch = 1'b0; bus.zero = 1'b0;
    serve("t4b", 32'h40, 32'h0000_0013, 0);
    @(negedge clk);
    check("t4b_mis", 32'(misalign_err), 32'd1);

    // withheld ack -> timeout after 15 wait cycles, late ack still captured
    check("t5_req0",  32'(bus.imem_req), 32'd1);
    check("t5_addr0", bus.imem_addr,     32'h44);
    repeat (14) @(negedge clk);
    check("t5_tmo14", 32'(timeout_err), 32'd0);
    repeat (6) @(negedge clk);
    check("t5_tmo20", 32'(timeout_err),     32'd1);
    check("t5_req20", 32'(bus.imem_req),    32'd1);
    check("t5_vld20", 32'(bus.instr_valid), 32'd0);
    serve("t5_late", 32'h44, 32'hCAFE_0013, 0);
    check("t5_tmo_st", 32'(timeout_err), 32'd1);
    @(negedge clk);

    // reset mid-REQ with a coincident ack
    check("t6_req", 32'(bus.imem_req), 32'd1);
    bus.imem_rdata = 32'h1111_1111;
    bus.imem_ack   = 1'b1;
    rst_n          = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("t6_vld",   32'(bus.instr_valid), 32'd0);
    check("t6_req0",  32'(bus.imem_req),    32'd0);
    check("t6_instr", bus.instr,            32'd0);
    check("t6_pcout", bus.pc_out,           32'd0);
    check("t6_mis",   32'(misalign_err),    32'd0);
    check("t6_tmo",   32'(timeout_err),     32'd0);
    rst_n = 1'b1;
    serve("t6_refetch", 32'h0, 32'h0000_2083, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
